// File: rtl/button_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// button_ctrl_pkg
// Purpose : Shared constants and helpers for the button controller slice.
//           Holds button index constants, the long-press counter width and a
//           width helper used to size the prescaler and debounce counters.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package button_ctrl_pkg;

  // Button lanes inside button_ctrl
  localparam int BTN_MAGIC = 0;
  localparam int BTN_PAUSE = 1;
  localparam int NUM_BTN   = 2;

  // Long-press hold counter is a fixed 11-bit saturating ms counter
  localparam int LP_CNT_W  = 11;

  // Number of bits needed to hold values 0..max_val (at least 1)
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Purpose : 2-FF synchronizer followed by a ms-tick debouncer for one
//           active-low raw button.
// Ports   : clk28      in  system clock
//           rst_n      in  asynchronous active-low reset
//           i_btn_n    in  raw button, asynchronous, active-low
//           i_tick     in  1-cycle ms tick
//           o_stable_n out debounced level (1 = released)
//           o_press    out 1-cycle pulse in the cycle a press is accepted
//           o_agree    out synced input currently equals the debounced level
// -----------------------------------------------------------------------------
module button_debounce
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MS = 16
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic i_btn_n,
  input  logic i_tick,
  output logic o_stable_n,
  output logic o_press,
  output logic o_agree
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable_n;
  logic [CNT_W-1:0] r_cnt;

  logic w_differ;
  logic w_accept;

  assign w_differ = (r_sync2 != r_stable_n);
  // The tick that brings the count to DEBOUNCE_MS commits the new level
  assign w_accept = w_differ && i_tick && (r_cnt == CNT_LAST);

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable_n <= 1'b1;
      r_cnt      <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (w_accept) begin
          r_stable_n <= r_sync2;
          r_cnt      <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_stable_n = r_stable_n;
  // Combinational so the consumer reacts on the same edge the level commits
  assign o_press    = w_accept && !r_sync2;
  assign o_agree    = !w_differ;

endmodule

// File: rtl/button_ctrl.sv
// -----------------------------------------------------------------------------
// button_ctrl
// Purpose : Magic (NMI/config) and pause button handling. Raw buttons are
//           synchronized and debounced against a 1 ms tick; magic requests are
//           held pending until the next frame boundary; pause is a toggle
//           latch fed by the button and a keyboard hotkey.
// Config  : define BUTTON_LONGPRESS_EN to add long-press detection on the
//           magic button (reboot_req pulse after LONGPRESS_MS held ms).
//           Without it reboot_req is tied to 0.
// Ports   : clk28        in  28 MHz system clock
//           rst_n        in  asynchronous active-low reset
//           n_int        in  current frame interrupt level
//           n_int_next   in  next-cycle frame interrupt level
//           btn_magic_n  in  raw magic button, active-low
//           btn_pause_n  in  raw pause button, active-low
//           kbd_magic    in  1-cycle keyboard magic hotkey
//           kbd_pause    in  1-cycle keyboard pause hotkey
//           magic_button out high while a magic request is pending
//           pause_button out pause latch level
//           reboot_req   out 1-cycle long-press pulse
// -----------------------------------------------------------------------------
module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 28000,
  parameter int DEBOUNCE_MS  = 16,
  parameter int LONGPRESS_MS = 2000
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic n_int,
  input  logic n_int_next,
  input  logic btn_magic_n,
  input  logic btn_pause_n,
  input  logic kbd_magic,
  input  logic kbd_pause,
  output logic magic_button,
  output logic pause_button,
  output logic reboot_req
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_WAIT_REL = 2'd2
  } magic_state_t;

  localparam int                PRESC_W    = cnt_width(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  // ---------------------------------------------------------------------------
  // 1 ms tick prescaler
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] r_presc;
  logic               r_tick;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= (r_presc == PRESC_LAST);
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounced buttons
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] w_raw_n;
  logic [NUM_BTN-1:0] w_stable_n;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_agree;
  logic [NUM_BTN-1:0] w_edge;
  logic [NUM_BTN-1:0] r_armed;

  assign w_raw_n[BTN_MAGIC] = btn_magic_n;
  assign w_raw_n[BTN_PAUSE] = btn_pause_n;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_MS (DEBOUNCE_MS)
      ) u_debounce (
        .clk28      (clk28),
        .rst_n      (rst_n),
        .i_btn_n    (w_raw_n[gi]),
        .i_tick     (r_tick),
        .o_stable_n (w_stable_n[gi]),
        .o_press    (w_press[gi]),
        .o_agree    (w_agree[gi])
      );

      // A button held through reset is accepted as pressed by the debouncer,
      // but must not count as a fresh press: edges are only honoured once the
      // button has been seen settled-released on a tick since reset.
      always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
          r_armed[gi] <= 1'b0;
        end else if (r_tick && w_stable_n[gi] && w_agree[gi]) begin
          r_armed[gi] <= 1'b1;
        end
      end

      assign w_edge[gi] = w_press[gi] && r_armed[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Magic request FSM
  // ---------------------------------------------------------------------------
  magic_state_t r_state;
  magic_state_t w_state_next;
  logic         w_frame_bound;
  logic         w_magic_held;

  assign w_frame_bound = n_int && !n_int_next;
  assign w_magic_held  = !w_stable_n[BTN_MAGIC];

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A boundary seen while still in IDLE is not consumed, so a press that
  // coincides with a boundary waits for the following one.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_edge[BTN_MAGIC] || kbd_magic) begin
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_frame_bound) begin
          w_state_next = w_magic_held ? ST_WAIT_REL : ST_IDLE;
        end
      end
      ST_WAIT_REL: begin
        if (!w_magic_held) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign magic_button = (r_state == ST_PENDING);

  // ---------------------------------------------------------------------------
  // Pause latch: both sources OR-ed so a coincident pair toggles once
  // ---------------------------------------------------------------------------
  logic r_pause;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_pause <= 1'b0;
    end else if (w_edge[BTN_PAUSE] || kbd_pause) begin
      r_pause <= !r_pause;
    end
  end

  assign pause_button = r_pause;

  // ---------------------------------------------------------------------------
  // Long-press reboot request
  // ---------------------------------------------------------------------------
`ifdef BUTTON_LONGPRESS_EN
  localparam bit                  LP_REACHABLE = (LONGPRESS_MS >= 1) &&
                                                 (LONGPRESS_MS <= ((1 << LP_CNT_W) - 1));
  localparam logic [LP_CNT_W-1:0] LP_LAST      = LP_CNT_W'(LONGPRESS_MS - 1);
  localparam logic [LP_CNT_W-1:0] LP_MAX       = {LP_CNT_W{1'b1}};

  logic [LP_CNT_W-1:0] r_lp_cnt;
  logic                r_reboot;

  // Counter saturates past the target, so the match occurs once per press
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_lp_cnt <= '0;
      r_reboot <= 1'b0;
    end else if (!w_magic_held) begin
      r_lp_cnt <= '0;
      r_reboot <= 1'b0;
    end else begin
      r_reboot <= LP_REACHABLE && r_tick && (r_lp_cnt == LP_LAST);
      if (r_tick && (r_lp_cnt != LP_MAX)) begin
        r_lp_cnt <= r_lp_cnt + 1'b1;
      end
    end
  end

  assign reboot_req = r_reboot;
`else
  assign reboot_req = 1'b0;
`endif

endmodule

// File: tb/tb_button_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_ctrl
// Purpose : Directed self-checking bench for button_ctrl with TICK_DIV=28,
//           DEBOUNCE_MS=4, LONGPRESS_MS=10. Works with or without
//           BUTTON_LONGPRESS_EN defined.
// Timing  : inputs are driven and outputs sampled on the falling edge. cyc
//           counts rising edges since reset release; the ms tick is high in
//           the cycle where cyc is a nonzero multiple of TD. A button driven
//           low in such a cycle N is accepted in cycle N+4*TD, so a magic
//           request becomes visible at cycle N+4*TD+1.
// -----------------------------------------------------------------------------
module tb_button_ctrl;

  localparam int TD = 28;
  localparam int DB = 4;
  localparam int LP = 10;
  localparam int ACCEPT = DB * TD;  // cycles from aligned press to acceptance

  logic clk28       = 1'b0;
  logic rst_n       = 1'b0;
  logic n_int       = 1'b1;
  logic n_int_next  = 1'b1;
  logic btn_magic_n = 1'b1;
  logic btn_pause_n = 1'b1;
  logic kbd_magic   = 1'b0;
  logic kbd_pause   = 1'b0;
  logic magic_button;
  logic pause_button;
  logic reboot_req;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk28 = ~clk28;

  always @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  button_ctrl #(
    .TICK_DIV     (TD),
    .DEBOUNCE_MS  (DB),
    .LONGPRESS_MS (LP)
  ) dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .n_int        (n_int),
    .n_int_next   (n_int_next),
    .btn_magic_n  (btn_magic_n),
    .btn_pause_n  (btn_pause_n),
    .kbd_magic    (kbd_magic),
    .kbd_pause    (kbd_pause),
    .magic_button (magic_button),
    .pause_button (pause_button),
    .reboot_req   (reboot_req)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk28);
  endtask

  // Move to the next falling edge inside a tick cycle (bounded)
  task automatic align_tick();
    int guard;
    guard = 0;
    @(negedge clk28);
    while (((cyc % TD) != 0 || cyc == 0) && guard < 4 * TD) begin
      @(negedge clk28);
      guard++;
    end
    if (guard >= 4 * TD) check("align_tick", guard, 0);
  endtask

  initial begin
    int hi;
    int pulses;
    int first;

    // ---- reset state, hotkeys ignored while in reset ----
    step(2);
    kbd_magic = 1'b1;
    kbd_pause = 1'b1;
    step(1);
    kbd_magic = 1'b0;
    kbd_pause = 1'b0;
    check("rst_magic", magic_button, 0);
    check("rst_pause", pause_button, 0);
    check("rst_reboot", reboot_req, 0);
    step(1);
    rst_n = 1'b1;
    step(3 * TD);

    // ---- glitch of 2 ticks on magic: no request ----
    align_tick();
    btn_magic_n = 1'b0;
    step(2 * TD);
    btn_magic_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 8 * TD; i++) begin
      @(negedge clk28);
      if (magic_button) hi = 1;
    end
    check("glitch_ignored", hi, 0);

    // ---- 4-tick press: request one cycle after the 4th tick ----
    align_tick();
    btn_magic_n = 1'b0;
    step(ACCEPT);
    check("deb_at_tick4", magic_button, 0);
    step(1);
    check("deb_rise", magic_button, 1);

    // ---- boundary while held: PENDING -> WAIT_REL ----
    step(4);
    n_int_next = 1'b0;
    check("pend_at_bound", magic_button, 1);
    step(1);
    n_int_next = 1'b1;
    check("pend_exit", magic_button, 0);

    // ---- kbd_magic ignored in WAIT_REL ----
    kbd_magic = 1'b1;
    step(1);
    kbd_magic = 1'b0;
    check("waitrel_kbd_1", magic_button, 0);
    step(3);
    check("waitrel_kbd_2", magic_button, 0);
    btn_magic_n = 1'b1;
    step(6 * TD);

    // ---- kbd_magic then boundary 1000 cycles later ----
    kbd_magic = 1'b1;
    hi = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk28);
      if (magic_button) hi++;
      if (i == 1) kbd_magic = 1'b0;
      if (i == 1000) n_int_next = 1'b0;
    end
    step(1);
    n_int_next = 1'b1;
    check("kbd_high_cycles", hi, 1000);
    check("kbd_after_bound", magic_button, 0);

    // ---- hotkey coincides with a boundary in IDLE: window not zero ----
    step(5);
    kbd_magic  = 1'b1;
    n_int_next = 1'b0;
    step(1);
    kbd_magic  = 1'b0;
    n_int_next = 1'b1;
    check("coinc_enter", magic_button, 1);
    step(50);
    check("coinc_hold", magic_button, 1);
    n_int_next = 1'b0;
    step(1);
    n_int_next = 1'b1;
    check("coinc_exit", magic_button, 0);

    // ---- pause: button edge and hotkey in the same cycle toggle once ----
    check("pause_init", pause_button, 0);
    align_tick();
    btn_pause_n = 1'b0;
    step(ACCEPT);
    kbd_pause = 1'b1;
    check("pause_pre", pause_button, 0);
    step(1);
    kbd_pause = 1'b0;
    check("pause_once", pause_button, 1);
    step(10);
    check("pause_stay", pause_button, 1);
    btn_pause_n = 1'b1;
    step(6 * TD);
    check("pause_release", pause_button, 1);
    kbd_pause = 1'b1;
    step(1);
    kbd_pause = 1'b0;
    check("pause_kbd_off", pause_button, 0);

    // ---- long press: held ~15 ticks after acceptance ----
    step(TD);
    align_tick();
    btn_magic_n = 1'b0;
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk28);
      if (reboot_req) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == ACCEPT + 1) check("lp_magic_rise", magic_button, 1);
      if (i == 200) n_int_next = 1'b0;
      if (i == 201) n_int_next = 1'b1;
      if (i == ACCEPT + 15 * TD) btn_magic_n = 1'b1;
    end
`ifdef BUTTON_LONGPRESS_EN
    check("lp_pulses", pulses, 1);
    check("lp_pulse_cycle", first, ACCEPT + LP * TD + 1);
`else
    check("lp_pulses", pulses, 0);
`endif
    check("lp_back_idle", magic_button, 0);

    // ---- reset in PENDING; button held through reset ----
    step(TD);
    align_tick();
    btn_magic_n = 1'b0;
    step(ACCEPT + 1);
    check("rp_pending", magic_button, 1);
    step(2);
    rst_n = 1'b0;
    #1;
    check("rp_async_clr", magic_button, 0);
    step(3);
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 20 * TD; i++) begin
      @(negedge clk28);
      if (magic_button) hi = 1;
    end
    check("rp_held_noreq", hi, 0);
    btn_magic_n = 1'b1;
    step(8 * TD);
    check("rp_release", magic_button, 0);
    align_tick();
    btn_magic_n = 1'b0;
    step(ACCEPT + 1);
    check("rp_repress", magic_button, 1);
    btn_magic_n = 1'b1;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_ctrl.md
BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 28000, meaning clk28 cycles per 1 ms tick.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 16, meaning the stable-input time needed to accept a change.
REQ-003 SHALL have parameter LONGPRESS_MS, default 2000, meaning the hold time for a reboot request.
REQ-004 SHALL have port clk28  in  1  system clock, 28 MHz.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports n_int and n_int_next  in  1 each  current and next-cycle frame interrupt level.
REQ-007 SHALL have ports btn_magic_n and btn_pause_n  in  1 each  raw physical buttons, asynchronous, active-low.
REQ-008 SHALL have ports kbd_magic and kbd_pause  in  1 each  single-cycle clk28-synchronous keyboard hotkey pulses.
REQ-009 SHALL have port magic_button  out  1  magic request level to the NMI/config block.
REQ-010 SHALL have port pause_button  out  1  pause latch level.
REQ-011 SHALL have port reboot_req  out  1  single-cycle long-press pulse.

Function
REQ-012 SHALL pass each raw button through a 2-FF synchronizer before any other logic.
REQ-013 SHALL generate a 1-cycle ms tick every TICK_DIV clk28 cycles from a free-running prescaler.
REQ-014 SHALL, in each debouncer, count ticks while the synced input differs from the stable value, update the stable value when the count reaches DEBOUNCE_MS, and clear the count on any agreement.
REQ-015 SHALL use a magic FSM with states IDLE, PENDING and WAIT_REL.
REQ-016 SHALL move IDLE->PENDING on a debounced magic press edge or on kbd_magic.
REQ-017 SHALL drive magic_button high exactly while in PENDING.
REQ-018 SHALL define frame boundary as the cycle where n_int=1 and n_int_next=0.
REQ-019 SHALL, in PENDING, leave on the cycle after a frame boundary: to WAIT_REL if debounced magic is pressed, else to IDLE.
REQ-020 SHALL move WAIT_REL->IDLE on debounced release.
REQ-021 SHALL ignore kbd_magic outside IDLE.
REQ-022 SHALL, if a press edge and a frame boundary coincide in IDLE, enter PENDING and hold it until the next boundary, so the pending window is never zero-length.
REQ-023 SHALL toggle the pause latch on a debounced pause press edge or on kbd_pause.
REQ-024 SHALL toggle the pause latch only once when both pause sources fire in the same cycle.
REQ-025 SHALL drive pause_button from the pause latch.

Reset
REQ-026 SHALL, while rst_n=0, hold synchronizers and stable values at released (1), counters, prescaler and pause latch at 0, FSM at IDLE, and all outputs at 0.
REQ-027 SHALL, for a button held through reset, see a press edge only after a full debounce following reset release.

Configuration
REQ-028 SHALL implement long-press detection when macro BUTTON_LONGPRESS_EN is defined: an 11-bit saturating ms counter runs while debounced magic is pressed and clears on release.
REQ-029 SHALL, with BUTTON_LONGPRESS_EN defined, pulse reboot_req for 1 cycle when the counter reaches LONGPRESS_MS, at most once per press.
REQ-030 SHALL, without BUTTON_LONGPRESS_EN, tie reboot_req to 0 and omit the counter; magic behaviour is unchanged either way.

Structure
REQ-031 SHALL take no new shared-package typedefs; the magic FSM state enum is local to the module.
REQ-032 SHALL instantiate sub-module button_debounce (synchronizer plus debouncer) twice, with the tick as an input.

Verification
REQ-033 SHALL verify, with TICK_DIV=28 and DEBOUNCE_MS=4: btn_magic_n low with a 2-tick glitch -> no change; held 4 ticks -> magic_button rises within 1 cycle of the 4th tick.
REQ-034 SHALL verify: kbd_magic pulse, then a frame boundary 1000 cycles later -> magic_button high 1000 cycles and low on the cycle after the boundary.
REQ-035 SHALL verify: kbd_pause and a debounced pause edge in the same cycle -> pause_button 0->1 once; a second kbd_pause -> 0.
REQ-036 SHALL verify, with BUTTON_LONGPRESS_EN and LONGPRESS_MS=10: magic held 15 ticks -> exactly one reboot_req pulse at tick 10; without the macro -> none.
REQ-037 SHALL verify: rst_n asserted while in PENDING -> magic_button 0 immediately; button still held after release -> no new request until release then re-press.
REQ-038 SHALL verify: kbd_magic while in WAIT_REL -> ignored, magic_button stays 0.
